// File: rtl/uart_tx_sched_pkg.sv
// Shared types and frame constants for the UART transmit scheduler.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_FRAME = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_e;

    // Start, parity and stop bits wrapped around the data bits.
    localparam int unsigned FRAME_OVERHEAD = 3;

    function automatic int unsigned frame_len(input int unsigned data_width);
        return data_width + FRAME_OVERHEAD;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, with wrap.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               valid
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_W:0]        sum;

    // Rotate so bit 0 is the pointer position; the lowest set bit then wins.
    always_comb begin
        dbl    = {req, req};
        rot    = NUM_REQ'(dbl >> ptr);
        winner = '0;
        valid  = 1'b0;
        sum    = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = {1'b0, ptr} + (ID_W+1)'(i);
                if (sum >= (ID_W+1)'(NUM_REQ)) begin
                    sum = sum - (ID_W+1)'(NUM_REQ);
                end
                winner = sum[ID_W-1:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte sources;
// times each frame and the inter-frame gap itself since the transmitter has no busy flag.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned GAP_CYCLES = 1,
    localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          tx_clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic                          tx_start_n,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int unsigned FRAME_LEN = frame_len(DATA_WIDTH);
    localparam int unsigned CNT_MAX   = (FRAME_LEN > GAP_CYCLES) ? FRAME_LEN : GAP_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    sched_state_e          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       win_id, id_d;
    logic                  win_valid;
    logic [DATA_WIDTH-1:0] win_data, data_d;
    logic [NUM_REQ-1:0]    win_onehot, ack_d;
    logic                  start_n_d, busy_d, done_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (win_id),
        .valid  (win_valid)
    );

    // Byte and ack lane of the current arbitration winner.
    always_comb begin
        win_data   = '0;
        win_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                win_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge tx_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            req_ack    <= '0;
            tx_start_n <= 1'b1;
            tx_data    <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            req_ack    <= ack_d;
            tx_start_n <= start_n_d;
            tx_data    <= data_d;
            grant_id   <= id_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

    // Outputs are computed for the state being entered, so registering them lines up with it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        data_d    = tx_data;
        id_d      = grant_id;
        ack_d     = '0;
        start_n_d = 1'b1;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && win_valid) begin
                    state_d   = ST_ISSUE;
                    data_d    = win_data;
                    id_d      = win_id;
                    ptr_d     = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
                    ack_d     = win_onehot;
                    start_n_d = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_FRAME;
                cnt_d   = CNT_W'(1);
                busy_d  = 1'b1;
            end
            ST_FRAME: begin
                if (cnt_q == CNT_W'(FRAME_LEN)) begin
                    if (GAP_CYCLES != 0) begin
                        state_d = ST_GAP;
                        cnt_d   = CNT_W'(1);
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    busy_d = 1'b1;
                    done_d = (cnt_q == CNT_W'(FRAME_LEN - 1));
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    busy_d = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: a cycle-count reference model predicts grants
// and frame timing; a negedge monitor pops and compares.
module tb_uart_tx_sched;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int GAP = 1;
    localparam int FL  = DW + 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N*DW-1:0]   req_data = '0;

    logic [N-1:0]      req_ack, req_ack_z;
    logic              tx_start_n, tx_start_n_z;
    logic [DW-1:0]     tx_data, tx_data_z;
    logic [1:0]        grant_id, grant_id_z;
    logic              busy, busy_z;
    logic              frame_done, frame_done_z;

    always #5 clk = ~clk;

    uart_tx_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP)) u_dut (
        .tx_clk(clk), .reset(reset), .enable(enable), .req(req), .req_data(req_data),
        .req_ack(req_ack), .tx_start_n(tx_start_n), .tx_data(tx_data),
        .grant_id(grant_id), .busy(busy), .frame_done(frame_done)
    );

    uart_tx_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(0)) u_dut_gap0 (
        .tx_clk(clk), .reset(reset), .enable(enable), .req(req), .req_data(req_data),
        .req_ack(req_ack_z), .tx_start_n(tx_start_n_z), .tx_data(tx_data_z),
        .grant_id(grant_id_z), .busy(busy_z), .frame_done(frame_done_z)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: grant rules and frame/gap timing as cycle arithmetic.
    typedef struct {
        int id;
        int data;
        int cyc;
    } grant_t;

    grant_t exp_q[$];
    int cyc       = 0;
    int next_eval = 0;
    int m_ptr     = 0;
    int m_strobe  = -1000;
    int m_data    = 0;
    int m_id      = 0;
    int m_w;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_ptr     = 0;
            next_eval = cyc + 1;
            m_strobe  = -1000;
            m_data    = 0;
            m_id      = 0;
            exp_q.delete();
        end else if (cyc >= next_eval && enable && req != '0) begin
            m_w = -1;
            for (int k = 0; k < N; k++) begin
                if (m_w < 0 && req[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
            end
            m_data    = int'(req_data[m_w*DW +: DW]);
            m_id      = m_w;
            m_ptr     = (m_w + 1) % N;
            m_strobe  = cyc;
            next_eval = cyc + 1 + FL + GAP + 1;
            exp_q.push_back('{m_w, m_data, cyc});
        end
    end

    // Monitor: strobes pop the scoreboard; per-cycle timing outputs follow the model.
    grant_t g;
    logic [N-1:0] exp_ack;
    always @(negedge clk) begin
        if (!tx_start_n) begin
            if (exp_q.size() != 0) g = exp_q.pop_front();
            else g = '{-1, -1, -1};
            chk("strobe_cycle", cyc, g.cyc);
            chk("strobe_grant_id", 32'(grant_id), g.id);
            chk("strobe_tx_data", 32'(tx_data), g.data);
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            chk("strobe_missing", 32'(tx_start_n), 0);
            void'(exp_q.pop_front());
        end
        exp_ack = (cyc == m_strobe) ? N'(1 << m_id) : '0;
        chk("req_ack", 32'(req_ack), 32'(exp_ack));
        chk("busy", 32'(busy), 32'(cyc >= m_strobe && cyc <= m_strobe + FL + GAP));
        chk("frame_done", 32'(frame_done), 32'(cyc == m_strobe + FL));
        chk("tx_data_hold", 32'(tx_data), m_data);
        chk("grant_id_hold", 32'(grant_id), m_id);
    end

    // Zero-gap instance: strobe spacing under continuous requests.
    bit cont   = 1'b0;
    int prev_z = -1;
    always @(negedge clk) begin
        if (!tx_start_n_z) begin
            if (cont && prev_z >= 0) chk("gap0_spacing", cyc - prev_z, FL + 2);
            prev_z = cont ? cyc : -1;
        end
    end

    bit hold  = 1'b0;
    bit found = 1'b0;

    task automatic tick();
        @(negedge clk);
        if (!hold) req = req & ~req_ack;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_strobe(input string name, input int limit);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            tick();
            if (!tx_start_n) found = 1'b1;
        end
        chk(name, 32'(found), 1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_tx_start_n", 32'(tx_start_n), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_ack", 32'(req_ack), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
    endtask

    initial begin
        ticks(3);
        check_reset_outputs();

        // Single requester, first strobe latency and frame_done position.
        reset = 1'b0;
        enable = 1'b1;
        req_data[0 +: DW] = 8'hA5;
        req = 4'b0001;
        tick();
        chk("first_strobe_latency", 32'(tx_start_n), 0);
        chk("first_ack", 32'(req_ack), 1);
        chk("first_tx_data", 32'(tx_data), 32'hA5);
        ticks(FL);
        chk("first_frame_done", 32'(frame_done), 1);
        ticks(20);

        // All four held: round-robin order with bytes 11/22/33/44.
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        hold = 1'b1;
        cont = 1'b1;
        prev_z = -1;
        req = 4'b1111;
        ticks(80);
        cont = 1'b0;
        hold = 1'b0;
        req = '0;
        ticks(20);

        // Pointer parked at 3 after granting 2; 4'b0101 must wrap to requester 0.
        req_data[2*DW +: DW] = 8'h5C;
        req = 4'b0100;
        wait_strobe("ptr_setup_strobe", 20);
        chk("ptr_setup_grant", 32'(grant_id), 2);
        ticks(20);
        req_data[0 +: DW] = 8'h0F;
        req_data[2*DW +: DW] = 8'hF0;
        req = 4'b0101;
        wait_strobe("ptr_wrap_strobe", 5);
        chk("ptr_wrap_grant", 32'(grant_id), 0);
        ticks(40);

        // enable dropped mid-frame: frame and gap complete, then hold idle.
        hold = 1'b1;
        req = 4'b1111;
        wait_strobe("en_first_strobe", 20);
        ticks(4);
        enable = 1'b0;
        ticks(30);
        chk("en_low_busy", 32'(busy), 0);
        chk("en_low_no_strobe", 32'(tx_start_n), 1);
        enable = 1'b1;
        tick();
        chk("en_restart_strobe", 32'(tx_start_n), 0);

        // Reset mid-frame aborts, then requester 1 is served.
        wait_strobe("rst_mid_strobe", 20);
        ticks(4);
        reset = 1'b1;
        tick();
        check_reset_outputs();
        reset = 1'b0;
        hold = 1'b0;
        req_data[1*DW +: DW] = 8'h3C;
        req = 4'b0010;
        wait_strobe("post_reset_strobe", 5);
        chk("post_reset_grant", 32'(grant_id), 1);
        ticks(20);

        // Randomised traffic: raises, early drops, enable toggling, rare resets.
        for (int c = 0; c < 2000; c++) begin
            tick();
            enable = ($urandom_range(0, 19) != 0);
            reset = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req_data[i*DW +: DW] = 8'($urandom);
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(0, 49) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end

        reset = 1'b0;
        enable = 1'b1;
        req = '0;
        ticks(40);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
